// File: rtl/axi_slave_write_mem.sv
// AXI4 write-only slave backed by a byte-lane memory; one burst in flight at a time.
// A registered backdoor port reads any memory word for inspection.
module axi_slave_write_mem #(
  parameter int addr_width = 32,
  parameter int data_width = 64,
  parameter int mem_depth  = 256
) (
  input  logic                         AClk,
  input  logic                         ARst,
  input  logic [7:0]                   AWID,
  input  logic [addr_width-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [data_width-1:0]        WDATA,
  input  logic [7:0]                   WSTRB,
  input  logic                         WLAST,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [7:0]                   BID,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [$clog2(mem_depth)-1:0] dbg_addr,
  output logic [63:0]                  dbg_rdata
);

  localparam int idx_w = $clog2(mem_depth);
  localparam logic [addr_width:0] mem_bytes = (addr_width + 1)'(mem_depth) << 3;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP} state_t;

  state_t                state_reg, state_next;
  logic [7:0]            id_reg, id_next;
  logic [addr_width-1:0] addr_reg, addr_next;
  logic [7:0]            len_reg, len_next;
  logic [7:0]            beat_reg, beat_next;
  logic                  fixed_reg, fixed_next;
  logic                  err_reg, err_next;
  logic                  awready_reg, awready_next;
  logic                  wready_reg, wready_next;
  logic                  bvalid_reg, bvalid_next;
  logic [7:0]            bid_reg, bid_next;
  logic [1:0]            bresp_reg, bresp_next;

  logic             aw_fire, w_fire, b_fire;
  logic             beat_last, out_of_range, beat_err, mem_we;
  logic [idx_w-1:0] mem_idx;

  assign aw_fire      = awready_reg & AWVALID;
  assign w_fire       = wready_reg & WVALID;
  assign b_fire       = bvalid_reg & BREADY;
  assign beat_last    = (beat_reg == len_reg);
  assign out_of_range = ({1'b0, addr_reg} >= mem_bytes);
  // The error flag is sticky: once a beat errs, the rest of the burst is discarded.
  assign beat_err     = err_reg | out_of_range | (WLAST != beat_last);
  assign mem_we       = w_fire & ~beat_err;
  assign mem_idx      = addr_reg[idx_w+2:3];

  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) begin
      state_reg   <= S_IDLE;
      id_reg      <= '0;
      addr_reg    <= '0;
      len_reg     <= '0;
      beat_reg    <= '0;
      fixed_reg   <= 1'b0;
      err_reg     <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bid_reg     <= '0;
      bresp_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      id_reg      <= id_next;
      addr_reg    <= addr_next;
      len_reg     <= len_next;
      beat_reg    <= beat_next;
      fixed_reg   <= fixed_next;
      err_reg     <= err_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bid_reg     <= bid_next;
      bresp_reg   <= bresp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    beat_next  = beat_reg;
    fixed_next = fixed_reg;
    err_next   = err_reg;
    bid_next   = bid_reg;
    bresp_next = bresp_reg;
    case (state_reg)
      S_IDLE: begin
        if (aw_fire) begin
          id_next    = AWID;
          addr_next  = AWADDR;
          len_next   = AWLEN;
          fixed_next = (AWBURST == 2'b00);
          beat_next  = '0;
          err_next   = (AWSIZE != 3'd3) | AWBURST[1] | (AWADDR[2:0] != 3'd0);
          state_next = S_WDATA;
        end
      end
      S_WDATA: begin
        if (w_fire) begin
          err_next  = beat_err;
          beat_next = beat_reg + 8'd1;
          if (!fixed_reg) addr_next = addr_reg + addr_width'(8);
          if (beat_last) begin
            state_next = S_WRESP;
            bid_next   = id_reg;
            bresp_next = beat_err ? 2'b10 : 2'b00;
          end
        end
      end
      S_WRESP: begin
        if (b_fire) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so that reset can hold them low.
  always_comb begin
    awready_next = (state_next == S_IDLE);
    wready_next  = (state_next == S_WDATA);
    bvalid_next  = (state_next == S_WRESP);
  end

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BID     = bid_reg;
  assign BRESP   = bresp_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [mem_depth];
      logic [7:0] lane_rd_reg;

      always_ff @(posedge AClk) begin
        if (mem_we && WSTRB[gi]) lane_mem[mem_idx] <= WDATA[gi*8 +: 8];
      end

      always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) lane_rd_reg <= '0;
        else       lane_rd_reg <= lane_mem[dbg_addr];
      end

      assign dbg_rdata[gi*8 +: 8] = lane_rd_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axi_slave_write_mem.sv
// Bench for axi_slave_write_mem: table of bursts with a response scoreboard and a memory model,
// plus hand-written reset and idle-channel sequences.
module tb_axi_slave_write_mem;

  logic        AClk = 1'b0;
  logic        ARst;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  dbg_addr;
  logic [63:0] dbg_rdata;

  axi_slave_write_mem dut (
    .AClk(AClk), .ARst(ARst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 AClk = ~AClk;

  typedef struct {
    logic [7:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0][63:0] data;
    logic [3:0][7:0]  strb;
    int               last_beat;
    int               bready_delay;
    logic [1:0]       exp_resp;
  } vec_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } sb_t;

  sb_t         sb[$];
  logic [63:0] model_mem [256];
  vec_t        vecs [12];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic vec_t mk(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3,
                              input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input int last_beat, input int dly, input logic [1:0] resp);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.data = {d3, d2, d1, d0};
    v.strb = {s3, s2, s1, s0};
    v.last_beat = last_beat; v.bready_delay = dly; v.exp_resp = resp;
    return v;
  endfunction

  task automatic dbg_read(input int idx, output logic [63:0] d);
    dbg_addr = idx[7:0];
    @(posedge AClk); #1;
    d = dbg_rdata;
  endtask

  // Apply one burst, update the memory model beat by beat, and retire the scoreboard entry.
  task automatic run_vec(input vec_t v, input int n);
    bit          rdy, ok, err, last;
    int          edges;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    sb_t         e;
    AWID = v.id; AWADDR = v.addr; AWLEN = v.len; AWSIZE = v.size; AWBURST = v.burst;
    AWVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = AWREADY; @(posedge AClk); #1; ok = rdy;
    end
    if (!ok) begin
      fail_now("aw_accept"); AWVALID = 1'b0; return;
    end
    e.id = v.id; e.resp = v.exp_resp; sb.push_back(e);
    chk("wready_after_aw", 64'(WREADY), 64'd1);
    chk("awready_in_wdata", 64'(AWREADY), 64'd0);
    // A stray address request stays valid during the data phase and must be ignored.
    AWID = 8'hEE; AWADDR = 32'h8; AWLEN = 8'd0; AWSIZE = 3'd3; AWBURST = 2'b01;
    a = v.addr;
    err = (v.size != 3'd3) || v.burst[1] || (v.addr[2:0] != 3'd0);
    edges = 0;
    for (int k = 0; k <= int'(v.len); k++) begin
      d = v.data[k % 4] ^ 64'(k / 4);
      s = v.strb[k % 4];
      last = (k == v.last_beat);
      WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        rdy = WREADY; @(posedge AClk); #1; edges++; ok = rdy;
      end
      if (!ok) begin
        fail_now("w_accept"); WVALID = 1'b0; AWVALID = 1'b0; return;
      end
      if (a >= 32'd2048) err = 1'b1;
      if (last != (k == int'(v.len))) err = 1'b1;
      if (!err)
        for (int b = 0; b < 8; b++)
          if (s[b]) model_mem[a[10:3]][b*8 +: 8] = d[b*8 +: 8];
      if (v.burst == 2'b01) a = a + 32'd8;
    end
    WVALID = 1'b0; WLAST = 1'b0; AWVALID = 1'b0;
    chk("w_cycles", 64'(edges), 64'(int'(v.len) + 1));
    chk("bvalid_latency", 64'(BVALID), 64'd1);
    chk("wready_in_wresp", 64'(WREADY), 64'd0);
    for (int i = 0; i < 20 && !BVALID; i++) begin
      @(posedge AClk); #1;
    end
    if (!BVALID) begin
      fail_now("bvalid_wait"); void'(sb.pop_front()); return;
    end
    for (int c = 0; c < v.bready_delay; c++) begin
      BREADY = 1'b0;
      chk("bvalid_held", 64'(BVALID), 64'd1);
      chk("bid_held", 64'(BID), 64'(sb[0].id));
      chk("bresp_held", 64'(BRESP), 64'(sb[0].resp));
      chk("awready_in_wresp", 64'(AWREADY), 64'd0);
      @(posedge AClk); #1;
    end
    BREADY = 1'b1;
    e = sb.pop_front();
    chk("bid", 64'(BID), 64'(e.id));
    chk("bresp", 64'(BRESP), 64'(e.resp));
    @(posedge AClk); #1;
    BREADY = 1'b0;
    chk("bvalid_after_b", 64'(BVALID), 64'd0);
    chk("awready_after_b", 64'(AWREADY), 64'd1);
    $display("txn %0d id=%h addr=%h len=%0d bid=%h bresp=%b expected_bresp=%b",
             n, v.id, v.addr, v.len, e.id, BRESP, e.resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    vec_t        init_v, rv;
    bit          seen;

    ARst = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; dbg_addr = '0;

    // Reset asserted asynchronously: outputs forced low at once.
    #3 ARst = 1'b0;
    #1;
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_wready", 64'(WREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_bid", 64'(BID), 64'd0);
    chk("rst_bresp", 64'(BRESP), 64'd0);
    chk("rst_dbg_rdata", dbg_rdata, 64'd0);
    @(posedge AClk); #1;
    chk("rst_awready_held", 64'(AWREADY), 64'd0);
    @(negedge AClk); ARst = 1'b1;
    @(posedge AClk); #1;
    chk("awready_after_release", 64'(AWREADY), 64'd1);
    chk("wready_idle", 64'(WREADY), 64'd0);

    // Write beats offered while idle are refused.
    WDATA = 64'hBADBADBADBADBAD0; WSTRB = 8'hFF; WLAST = 1'b1; WVALID = 1'b1;
    for (int c = 0; c < 2; c++) begin
      chk("wready_idle_beat", 64'(WREADY), 64'd0);
      @(posedge AClk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;

    // Fill the whole memory so later unchanged words are known.
    init_v = mk(8'h00, 32'h0, 8'd255, 3'd3, 2'b01,
                64'h0123456789ABCDEF, 64'h0F1E2D3C4B5A6978, 64'h1357924680ACE13F, 64'h7766554433221100,
                8'hFF, 8'hFF, 8'hFF, 8'hFF, 255, 0, 2'b00);
    run_vec(init_v, 0);

    vecs[0]  = mk(8'h5A, 32'h0, 8'd3, 3'd3, 2'b01,
                  64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 3, 0, 2'b00);
    vecs[1]  = mk(8'h21, 32'h10, 8'd1, 3'd3, 2'b00,
                  64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'h0, 64'h0,
                  8'hFF, 8'h0F, 8'hFF, 8'hFF, 1, 1, 2'b00);
    vecs[2]  = mk(8'h31, 32'h40, 8'd0, 3'd2, 2'b01,
                  64'hDEADDEADDEADDEAD, 64'h0, 64'h0, 64'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 2'b10);
    vecs[3]  = mk(8'h32, 32'h48, 8'd0, 3'd3, 2'b10,
                  64'hDEADDEADDEADDEAD, 64'h0, 64'h0, 64'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 2'b10);
    vecs[4]  = mk(8'h34, 32'h51, 8'd0, 3'd3, 2'b01,
                  64'hDEADDEADDEADDEAD, 64'h0, 64'h0, 64'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 2'b10);
    vecs[5]  = mk(8'h55, 32'h7F8, 8'd1, 3'd3, 2'b01,
                  64'hFEEDFACECAFEBEEF, 64'hDEADDEADDEADDEAD, 64'h0, 64'h0,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 0, 2'b10);
    vecs[6]  = mk(8'h66, 32'h100, 8'd2, 3'd3, 2'b01,
                  64'hC0C0C0C0C0C0C0C0, 64'hC1C1C1C1C1C1C1C1, 64'hC2C2C2C2C2C2C2C2, 64'h0,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 2'b10);
    vecs[7]  = mk(8'h67, 32'h200, 8'd1, 3'd3, 2'b01,
                  64'hE0E0E0E0E0E0E0E0, 64'hE1E1E1E1E1E1E1E1, 64'h0, 64'h0,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 0, 2'b10);
    vecs[8]  = mk(8'h77, 32'h300, 8'd2, 3'd3, 2'b01,
                  64'h9999000099990000, 64'h8888111188881111, 64'h7777222277772222, 64'h0,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 2, 5, 2'b10 ^ 2'b10);
    vecs[9]  = mk(8'h88, 32'h800, 8'd0, 3'd3, 2'b00,
                  64'hDEADDEADDEADDEAD, 64'h0, 64'h0, 64'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 2'b10);
    vecs[10] = mk(8'hC3, 32'h400, 8'd7, 3'd3, 2'b01,
                  64'h0102030405060708, 64'h1112131415161718, 64'h2122232425262728, 64'h3132333435363738,
                  8'hF0, 8'h0F, 8'h3C, 8'hFF, 7, 2, 2'b00);
    vecs[11] = mk(8'hD4, 32'h500, 8'd2, 3'd3, 2'b00,
                  64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8, 64'hC1C2C3C4C5C6C7C8, 64'h0,
                  8'h01, 8'h02, 8'h80, 8'hFF, 2, 0, 2'b00);

    for (int n = 0; n < 12; n++) run_vec(vecs[n], n + 1);

    // Known end states of specific bursts.
    dbg_read(0, d);   chk("mem0_incr", d, 64'h1111111111111111);
    dbg_read(1, d);   chk("mem1_incr", d, 64'h2222222222222222);
    dbg_read(2, d);   chk("mem2_fixed_merge", d, 64'hAAAAAAAA55555555);
    dbg_read(3, d);   chk("mem3_incr", d, 64'h4444444444444444);
    dbg_read(255, d); chk("mem255_edge", d, 64'hFEEDFACECAFEBEEF);

    // Reset during beat 2 of a 4-beat burst: beats 0-1 stay, no response.
    dbg_addr = 8'd0;
    rv = mk(8'h33, 32'h600, 8'd3, 3'd3, 2'b01,
            64'hB0B0B0B0B0B0B0B0, 64'hB1B1B1B1B1B1B1B1, 64'hB2B2B2B2B2B2B2B2, 64'hB3B3B3B3B3B3B3B3,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 3, 0, 2'b00);
    AWID = rv.id; AWADDR = rv.addr; AWLEN = rv.len; AWSIZE = rv.size; AWBURST = rv.burst; AWVALID = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      bit r; r = AWREADY; @(posedge AClk); #1; seen = r;
    end
    AWVALID = 1'b0;
    chk("abort_aw_accept", 64'(seen), 64'd1);
    for (int k = 0; k < 2; k++) begin
      WDATA = rv.data[k]; WSTRB = 8'hFF; WLAST = 1'b0; WVALID = 1'b1;
      chk("abort_wready", 64'(WREADY), 64'd1);
      @(posedge AClk); #1;
      model_mem[192 + k] = rv.data[k];
    end
    WDATA = rv.data[2]; WVALID = 1'b1;
    #2 ARst = 1'b0;
    #1;
    chk("abort_awready", 64'(AWREADY), 64'd0);
    chk("abort_wready_low", 64'(WREADY), 64'd0);
    chk("abort_bvalid", 64'(BVALID), 64'd0);
    chk("abort_bid", 64'(BID), 64'd0);
    chk("abort_dbg_rdata", dbg_rdata, 64'd0);
    @(posedge AClk); #1;
    @(negedge AClk);
    ARst = 1'b1; WVALID = 1'b0;
    @(posedge AClk); #1;
    chk("abort_awready_release", 64'(AWREADY), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | BVALID;
      @(posedge AClk); #1;
    end
    chk("abort_no_bvalid", 64'(seen), 64'd0);
    $display("txn abort id=%h addr=%h beats_written=2 bvalid_seen=%0d", rv.id, rv.addr, seen);

    // Full memory sweep against the model.
    for (int w = 0; w < 256; w++) begin
      dbg_read(w, d);
      chk($sformatf("mem_sweep[%0d]", w), d, model_mem[w]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_slave_write_mem.md
AXI_SLAVE_WRITE_MEM -- requirements
Module: axi_slave_write_mem

Interface
REQ-001 SHALL have parameter addr_width, default 32, AXI address width.
REQ-002 SHALL have parameter data_width, default 64, AXI data width; only 64 is supported.
REQ-003 SHALL have parameter mem_depth, default 256, number of 64-bit memory words; power of 2.
REQ-004 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-005 AClk  input  1  clock; all logic on rising edge.
REQ-006 ARst  input  1  asynchronous active-low reset.
REQ-007 AWID  input  8  write transaction ID.
REQ-008 AWADDR  input  addr_width  burst start byte address.
REQ-009 AWLEN  input  8  beats minus 1.
REQ-010 AWSIZE  input  3  beat size; only 3'd3 (8 bytes) is legal.
REQ-011 AWBURST  input  2  00 FIXED, 01 INCR; others illegal.
REQ-012 AWVALID / AWREADY  input / output  1 each  address handshake.
REQ-013 WDATA  input  data_width  write data.
REQ-014 WSTRB  input  8  byte enables.
REQ-015 WLAST  input  1  final beat marker.
REQ-016 WVALID / WREADY  input / output  1 each  data handshake.
REQ-017 BID  output  8  response ID; BRESP  output  2  00 OKAY, 10 SLVERR.
REQ-018 BVALID / BREADY  output / input  1 each  response handshake.
REQ-019 dbg_addr  input  log2(mem_depth)  backdoor word index; dbg_rdata  output  64  mem[dbg_addr], registered, 1-cycle latency.

Function
REQ-020 SHALL implement FSM IDLE, WDATA, WRESP; one burst outstanding at a time; AWLOCK/AWCACHE/AWPROT not used.
REQ-021 IDLE: AWREADY=1, WREADY=0, BVALID=0; on AWVALID&AWREADY capture ID/addr/len/burst, clear beat counter and error flag, go WDATA next cycle.
REQ-022 Error flag SHALL set at AW capture if AWSIZE!=3, AWBURST is 10 or 11, or AWADDR[2:0]!=0.
REQ-023 WDATA: AWREADY=0, WREADY=1; each WVALID&WREADY is one accepted beat; 1 beat/cycle sustained.
REQ-024 Beat address: FIXED keeps start address; INCR adds 8 per accepted beat; addr_width arithmetic, no wrap.
REQ-025 Beat address >= mem_depth*8 SHALL set error flag for that beat and remainder of burst.
REQ-026 Beat SHALL write memory byte lanes where WSTRB[i]=1 only if error flag is clear after that beat's checks; errored beats are discarded.
REQ-027 WLAST=1 on a beat other than beat AWLEN, or WLAST=0 on beat AWLEN, SHALL set error flag; burst always ends after exactly AWLEN+1 accepted beats.
REQ-028 After beat AWLEN accepted, go WRESP next cycle: BVALID=1, BID=captured ID, BRESP=10 if error flag else 00.
REQ-029 WRESP: BID/BRESP stable while BVALID&!BREADY; on BREADY go IDLE, AWREADY=1 the following cycle.
REQ-030 Latency: AW accept at T -> WREADY at T+1; last beat at T+1+AWLEN minimum -> BVALID at T+2+AWLEN.
REQ-031 W beats presented in IDLE or WRESP SHALL NOT be accepted (WREADY=0); AWVALID outside IDLE SHALL NOT be accepted.

Reset
REQ-032 ARst low SHALL immediately force state IDLE, AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, dbg_rdata=0, counters/flags 0; AWREADY=1 first edge after release.
REQ-033 Reset mid-burst SHALL abort with no B response; completed beats remain in memory; memory is not reset.

Verification
REQ-034 INCR AWADDR=0x0, AWLEN=3, AWID=0x5A, data 0x11..,0x22..,0x33..,0x44.., WSTRB=FF, BREADY=1 -> mem[0..3] written, BVALID at T+5, BID=0x5A, BRESP=00.
REQ-035 FIXED AWADDR=0x10, AWLEN=1, beat0 WSTRB=FF 0xAAAA..., beat1 WSTRB=0F 0x5555... -> mem[2]=0xAAAAAAAA55555555, BRESP=00.
REQ-036 AWSIZE=2 or AWBURST=10, AWLEN=0 -> beat accepted, memory unchanged, BRESP=10.
REQ-037 INCR AWADDR=0x7F8 (mem_depth=256), AWLEN=1 -> mem[255] written, beat1 discarded, BRESP=10; WLAST on beat 0 of AWLEN=2 -> BRESP=10 after 3 beats.
REQ-038 BREADY low 5 cycles -> BVALID/BID/BRESP held, AWREADY=0 until cycle after BREADY; ARst pulse during beat 2 of AWLEN=3 -> no BVALID, beats 0-1 in memory, AWREADY=1 after release.
